// File: rtl/adc_pkg.sv
// Shared ADC handshake definitions: responder state encoding and default
// conversion parameters, also reused by the sampling controller.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRIAL     = 2'd1,
    EOC_PULSE = 2'd2
  } adc_state_e;

  localparam int ADC_WIDTH    = 8;
  localparam int ADC_SETTLE   = 2;
  localparam int ADC_EOC_HOLD = 2;

endpackage

// File: rtl/adc_sar_responder.sv
// Successive-approximation ADC responder for the start/EOC/OE handshake.
// Tests one bit per SETTLE cycles against an external comparator, then pulses EOC.
module adc_sar_responder
  import adc_pkg::*;
#(
  parameter int WIDTH    = ADC_WIDTH,
  parameter int SETTLE   = ADC_SETTLE,
  parameter int EOC_HOLD = ADC_EOC_HOLD
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             OE,
  input  logic             comp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] dout,
  output logic             EOC,
  output logic             busy
);

  localparam int SET_W  = $clog2(SETTLE + 1);
  localparam int HOLD_W = $clog2(EOC_HOLD + 1);
  localparam int IDX_W  = $clog2(WIDTH);

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(EOC_HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_MSB     = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

  adc_state_e        state_reg, state_next;
  logic [WIDTH-1:0]  dac_reg, dac_next;
  logic [WIDTH-1:0]  data_reg, data_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [SET_W-1:0]  settle_reg, settle_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic              eoc_reg, eoc_next;
  logic              start_q;

  logic              start_edge;
  logic [WIDTH-1:0]  trial_code;
  logic [IDX_W-1:0]  idx_minus;

  assign start_edge = start & ~start_q;
  assign idx_minus  = idx_reg - 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      dac_reg    <= '0;
      data_reg   <= '0;
      idx_reg    <= '0;
      settle_reg <= '0;
      hold_reg   <= '0;
      eoc_reg    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dac_reg    <= dac_next;
      data_reg   <= data_next;
      idx_reg    <= idx_next;
      settle_reg <= settle_next;
      hold_reg   <= hold_next;
      eoc_reg    <= eoc_next;
      start_q    <= start;
    end
  end

  always_comb begin
    state_next  = state_reg;
    dac_next    = dac_reg;
    data_next   = data_reg;
    idx_next    = idx_reg;
    settle_next = settle_reg;
    hold_next   = hold_reg;
    eoc_next    = eoc_reg;

    // Current code with the bit under test resolved by the comparator.
    trial_code = dac_reg;
    if (!comp_in) trial_code[idx_reg] = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next  = TRIAL;
          idx_next    = IDX_MSB;
          dac_next    = MSB_CODE;
          settle_next = '0;
          eoc_next    = 1'b0;
        end
      end
      TRIAL: begin
        if (settle_reg != SETTLE_LAST) begin
          settle_next = settle_reg + 1'b1;
        end else if (idx_reg != '0) begin
          idx_next            = idx_minus;
          dac_next            = trial_code;
          dac_next[idx_minus] = 1'b1;
          settle_next         = '0;
        end else begin
          dac_next   = trial_code;
          data_next  = trial_code;
          eoc_next   = 1'b1;
          hold_next  = '0;
          state_next = EOC_PULSE;
        end
      end
      EOC_PULSE: begin
        if (hold_reg != HOLD_LAST) begin
          hold_next = hold_reg + 1'b1;
        end else begin
          eoc_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dac_code = dac_reg;
  assign dout     = OE ? data_reg : '0;
  assign EOC      = eoc_reg;
  assign busy     = (state_reg != IDLE);

endmodule
